// File: rtl/w5300_pkg.sv
// Shared types and constants for the W5300 parallel-bus responder.
package w5300_pkg;

  localparam int unsigned W5300_ADDR_W = 10;
  localparam int unsigned W5300_DATA_W = 16;

  localparam logic [W5300_ADDR_W-1:0] IDR_ADDR_DEF  = 10'h3FE;
  localparam logic [W5300_DATA_W-1:0] IDR_VALUE_DEF = 16'h5300;
  localparam logic [W5300_DATA_W-1:0] MR_RESET_DEF  = 16'h3800;
  localparam int unsigned             MR_RST_BIT    = 7;

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_READY = 1'b1
  } state_e;

  // One sampled bus beat: address and data travel together through the pipeline.
  typedef struct packed {
    logic [W5300_ADDR_W-1:0] addr;
    logic [W5300_DATA_W-1:0] data;
  } bus_word_t;

endpackage

// File: rtl/w5300_sync_2ff.sv
// Two-flop synchronizer for one asynchronous control line.
module w5300_sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/w5300_bus_responder.sv
// Chip-side responder for the W5300 16-bit async bus: register file, ID register,
// soft reset via MR bit 7, access counters and read/write collision detection.
module w5300_bus_responder
  import w5300_pkg::*;
#(
  parameter int unsigned             DEPTH_LOG2 = 6,
  parameter logic [W5300_DATA_W-1:0] MR_RESET   = MR_RESET_DEF,
  parameter logic [W5300_ADDR_W-1:0] IDR_ADDR   = IDR_ADDR_DEF,
  parameter logic [W5300_DATA_W-1:0] IDR_VALUE  = IDR_VALUE_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  inout  wire  [W5300_DATA_W-1:0] data,
  input  logic [W5300_ADDR_W-1:0] addr,
  input  logic                    cs_n,
  input  logic                    rd_n,
  input  logic                    we_n,
  output logic                    ready,
  output logic                    wr_strobe,
  output logic [W5300_ADDR_W-1:0] wr_addr,
  output logic [W5300_DATA_W-1:0] wr_data,
  output logic [15:0]             rd_count,
  output logic [15:0]             wr_count,
  output logic                    collision
);

  localparam int unsigned             DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0]   PTR_LAST = DEPTH_LOG2'(DEPTH - 1);

  logic cs_s, rd_s, we_s;
  logic cs_p, rd_p, we_p, rd_qual_p;
  bus_word_t bus_s1, bus_s2, bus_p;

  state_e state, state_nxt;
  logic [DEPTH_LOG2-1:0]   ptr;
  logic [W5300_DATA_W-1:0] mem [DEPTH];
  logic                    data_oe;
  logic [W5300_DATA_W-1:0] rd_word;

  logic                    read_c, collide_c, commit_c, rd_done_c, soft_rst_c;
  logic                    mem_we_c;
  logic [DEPTH_LOG2-1:0]   mem_idx_c;
  logic [W5300_DATA_W-1:0] mem_wdata_c;
  logic [W5300_DATA_W-1:0] rd_mux_c;

  function automatic logic in_range(input logic [W5300_ADDR_W-1:0] a);
    return 32'(a) < DEPTH;
  endfunction

  w5300_sync_2ff #(.RESET_VAL(1'b1)) u_sync_cs (.clk(clk), .rst_n(rst_n), .d(cs_n), .q(cs_s));
  w5300_sync_2ff #(.RESET_VAL(1'b1)) u_sync_rd (.clk(clk), .rst_n(rst_n), .d(rd_n), .q(rd_s));
  w5300_sync_2ff #(.RESET_VAL(1'b1)) u_sync_we (.clk(clk), .rst_n(rst_n), .d(we_n), .q(we_s));

  assign data = data_oe ? rd_word : {W5300_DATA_W{1'bz}};

  // Access decode and next-state logic.
  always_comb begin
    state_nxt   = state;
    read_c      = 1'b0;
    collide_c   = 1'b0;
    commit_c    = 1'b0;
    rd_done_c   = 1'b0;
    soft_rst_c  = 1'b0;
    mem_we_c    = 1'b0;
    mem_idx_c   = bus_p.addr[DEPTH_LOG2-1:0];
    mem_wdata_c = bus_p.data;
    rd_mux_c    = '0;

    if (in_range(bus_s2.addr)) begin
      rd_mux_c = mem[bus_s2.addr[DEPTH_LOG2-1:0]];
    end else if (bus_s2.addr == IDR_ADDR) begin
      rd_mux_c = IDR_VALUE;
    end

    case (state)
      S_CLEAR: begin
        mem_we_c    = 1'b1;
        mem_idx_c   = ptr;
        mem_wdata_c = (ptr == '0) ? MR_RESET : '0;
        if (ptr == PTR_LAST) begin
          state_nxt = S_READY;
        end
      end
      S_READY: begin
        collide_c = !cs_s && !rd_s && !we_s;
        read_c    = !cs_s && !rd_s &&  we_s;
        // A write whose low phase overlapped a read strobe (collision) is not committed.
        commit_c  = !cs_p && !we_p && we_s && rd_p;
        rd_done_c = rd_qual_p && rd_s;
        soft_rst_c = commit_c && (bus_p.addr == '0) && bus_p.data[MR_RST_BIT];
        mem_we_c  = commit_c && in_range(bus_p.addr) && !soft_rst_c;
        if (soft_rst_c) begin
          state_nxt = S_CLEAR;
        end
      end
      default: state_nxt = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_CLEAR;
    end else begin
      state <= state_nxt;
    end
  end

  // Register file has no reset; the clear sweep initialises it.
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      mem[mem_idx_c] <= mem_wdata_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= '0;
      bus_s1    <= '0;
      bus_s2    <= '0;
      bus_p     <= '0;
      cs_p      <= 1'b1;
      rd_p      <= 1'b1;
      we_p      <= 1'b1;
      rd_qual_p <= 1'b0;
      data_oe   <= 1'b0;
      rd_word   <= '0;
      ready     <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      rd_count  <= '0;
      wr_count  <= '0;
      collision <= 1'b0;
    end else begin
      bus_s1    <= '{addr: addr, data: data};
      bus_s2    <= bus_s1;
      bus_p     <= bus_s2;
      cs_p      <= cs_s;
      rd_p      <= rd_s;
      we_p      <= we_s;
      rd_qual_p <= read_c;
      data_oe   <= read_c;
      rd_word   <= rd_mux_c;
      ready     <= (state_nxt == S_READY);
      wr_strobe <= commit_c;
      collision <= collision | collide_c;

      if (state == S_CLEAR) begin
        ptr <= ptr + DEPTH_LOG2'(1);
      end else if (soft_rst_c) begin
        ptr <= '0;
      end

      if (commit_c) begin
        wr_addr  <= bus_p.addr;
        wr_data  <= bus_p.data;
        wr_count <= wr_count + 16'd1;
      end

      if (rd_done_c) begin
        rd_count <= rd_count + 16'd1;
      end
    end
  end

endmodule

// File: doc/w5300_bus_responder.md
Name: w5300_bus_responder

Overview:
- Synthesizable responder for the W5300 async 16-bit parallel bus, i.e. the chip side of the link that the host-side parallel interface drives.
- Samples cs_n/rd_n/we_n/addr/data in the clk domain.
- Serves reads from, and commits writes to, an internal word register file.
- Used for on-board loopback and for bench verification of the host interface without a physical W5300.

Parameters:
- DEPTH_LOG2, 6, register file holds 2**DEPTH_LOG2 16-bit words at word addresses 0..2**DEPTH_LOG2-1.
- MR_RESET, 16'h3800, value loaded into word 0 (MR) on every clear.
- IDR_ADDR, 10'h3FE, read-only identification address.
- IDR_VALUE, 16'h5300, value returned at IDR_ADDR.

Ports:
- clk  input  1  responder clock, ≥4x the host access rate.
- rst_n  input  1  asynchronous active-low reset.
- data  inout  16  bus data; driven only during a qualified read, else 'z.
- addr  input  10  word address from host.
- cs_n  input  1  chip select, active low.
- rd_n  input  1  read strobe, active low.
- we_n  input  1  write strobe, active low.
- ready  output  1  high when the clear sweep is done and accesses are served.
- wr_strobe  output  1  one-cycle pulse per committed write.
- wr_addr  output  10  address of the last committed write.
- wr_data  output  16  data of the last committed write.
- rd_count  output  16  committed reads, wraps at 16'hFFFF→0.
- wr_count  output  16  committed writes, wraps at 16'hFFFF→0.
- collision  output  1  sticky; set when rd and we are both active with cs active.

Behaviour:
- Reset: rst_n is asynchronous and active-low; clk is the clock. While rst_n is low, all of the following hold:
  - ready=0, wr_strobe=0, wr_addr=0, wr_data=0, rd_count=0, wr_count=0, collision=0.
  - data is 'z and all synchronizer stages are 1.
  - state=S_CLEAR with the clear pointer at 0.
- Input capture:
  - cs_n, rd_n and we_n pass through 2-flop synchronizers (reset to 1).
  - addr and data are registered through 2 stages in parallel, so they stay aligned with the control lines.
- State S_CLEAR:
  - Writes 0 to mem[ptr] each cycle; writes MR_RESET when ptr==0.
  - After ptr reaches 2**DEPTH_LOG2-1: go to S_READY and set ready=1 on the next cycle. The sweep takes exactly 2**DEPTH_LOG2 cycles.
  - All bus activity is ignored; data is not driven and counters are not touched.
- State S_READY:
  - Read:
    - Condition: cs_s=0, rd_s=0, we_s=1.
    - Next cycle, data_oe=1 and data drives the read word:
      - mem[addr_s] if addr_s < 2**DEPTH_LOG2;
      - IDR_VALUE if addr_s==IDR_ADDR;
      - 16'h0000 otherwise.
    - Latency from the rd_n pin falling to data driven: 3 clk.
    - data tracks addr_s while the read stays active.
    - data_oe drops the cycle after cs_s or rd_s goes high.
    - rd_count increments once per read, on the rising edge of rd_s.
  - Write:
    - Committed on the rising edge of we_s (prev=0, now=1), provided cs_s was 0 in the previous cycle.
    - Uses addr and data from the previous cycle, i.e. the values before the strobe released.
    - Effects: mem written if in range (out-of-range and IDR_ADDR writes are dropped but still counted); wr_strobe=1 for one cycle; wr_addr/wr_data updated; wr_count incremented.
  - Soft reset:
    - A committed write to address 0 with bit 7=1 goes to S_CLEAR the next cycle (ready=0, ptr=0).
    - MR is written by the sweep, not by the write data.
- Collision:
  - Condition: cs_s=0 with rd_s=0 and we_s=0 together.
  - Sets collision (sticky until rst_n), forces data_oe=0, and suppresses the read or write that coincides with the collision.
- Strobe without cs: strobe edges with cs_s=1 are ignored.
- Reset mid-access: data is released asynchronously and any partial write is discarded.

Decomposition:
- Shared package w5300_pkg holds:
  - state encoding S_CLEAR/S_READY;
  - constants IDR_ADDR_DEF=10'h3FE, IDR_VALUE_DEF=16'h5300, MR_RESET_DEF=16'h3800, MR_RST_BIT=7;
  - bus widths W5300_ADDR_W=10, W5300_DATA_W=16.
- One sub-module: w5300_sync_2ff, a 2-flop synchronizer with a reset value parameter, instantiated 3 times.

Test Plan:
- Release rst_n -> ready rises exactly 64 cycles later (DEPTH_LOG2=6); read addr 0 returns 16'h3800, addr 5 returns 16'h0000.
- Write 16'hA5C3 to addr 12, then read addr 12 -> data=16'hA5C3; wr_strobe pulses once with wr_addr=12; wr_count=1, rd_count=1; data is driven 3 clk after rd_n falls and is 'z 3 clk after rd_n rises.
- Read addr 10'h3FE -> 16'h5300. Write 16'h1234 to 10'h3FE, then read it -> still 16'h5300; wr_count increments. Read addr 100 -> 16'h0000.
- Write 16'h0080 to addr 0 after writing 16'hBEEF to addr 3 -> ready low for 64 cycles; afterwards addr 3 reads 0 and addr 0 reads 16'h3800.
- Assert rd_n and we_n low together with cs_n low -> collision=1 and stays 1; data stays 'z; no write and rd_count/wr_count unchanged.
- Toggle we_n with cs_n high, then pull rst_n low mid-read -> no commit; data goes 'z immediately; all outputs at reset values.
